matrix_mult_engine: RTL and testbench
=====================================

MATRIX_MULT_ENGINE -- requirements
Module: matrix_mult_engine

Interface
REQ-001 Parameter M, default 2: rows of A and of C.
REQ-002 Parameter N, default 3: columns of A, rows of B; MAC steps per element.
REQ-003 Parameter P, default 4: columns of B and of C.
REQ-004 Parameter DATA_WIDTH, default 8: A/B element width, two's complement.
REQ-005 Parameter SATURATE, default 1: 1 = clamp output on overflow, 0 = wrap (truncate).
REQ-006 Derived widths: AW = max(1,clog2(M*N)); BW = max(1,clog2(N*P)); RW = max(1,clog2(M)); CW = max(1,clog2(P)); OW = 2*DATA_WIDTH; ACC_W = 2*DATA_WIDTH+clog2(N)+2.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  single-cycle request to begin a run.
REQ-010 acc_mode  in  1  sampled with start; 1 = C := C + A*B, 0 = C := A*B.
REQ-011 a_in / a_addr / a_wen  in  DATA_WIDTH / AW / 1  A write port, row-major, index r*N+k.
REQ-012 b_in / b_addr / b_wen  in  DATA_WIDTH / BW / 1  B write port, row-major, index k*P+c.
REQ-013 c_out  out  OW  result element, signed.
REQ-014 c_row / c_col  out  RW / CW  coordinates of c_out.
REQ-015 c_valid  out  1  c_out/c_row/c_col valid.
REQ-016 c_ready  in  1  consumer accepts; transfer occurs when c_valid && c_ready at a rising edge.
REQ-017 busy  out  1  high from the edge sampling start until done.
REQ-018 done  out  1  one-cycle pulse after the last transfer.
REQ-019 overflow  out  1  sticky: an element exceeded the signed OW range this run.

Function
REQ-020 The FSM shall have states IDLE, MAC, OUT, FIN; reset state IDLE.
REQ-021 IDLE: on start=1, latch acc_mode, clear overflow, zero element indices (r=0, c=0), go to MAC; busy=1 from the next cycle.
REQ-022 MAC: exactly N cycles, k = 0..N-1; each cycle acc += A[r*N+k]*B[k*P+c] (full signed 2*DATA_WIDTH product sign-extended to ACC_W); acc starts at sign-extended stored C[r][c] if acc_mode else 0.
REQ-023 After the N-th MAC cycle, go to OUT; c_valid=1 with c_out = result, where result = acc if representable in OW, else clamp to +/-(2^(OW-1)) bounds (SATURATE=1) or acc[OW-1:0] (SATURATE=0); overflow set in either case.
REQ-024 The first c_valid shall be high in the cycle after the (N+1)-th rising edge following the edge that sampled start.
REQ-025 OUT: c_out, c_row, c_col held stable while c_valid && !c_ready; on transfer, store result into internal C[r][c], advance row-major (c increments, wraps to 0 with r+1), return to MAC, else go to FIN after element (M-1,P-1).
REQ-026 FIN: done=1 for one cycle, busy=0, next state IDLE; throughput with c_ready held high is N+1 cycles per element, M*P*(N+1)+1 cycles per run.
REQ-027 start while busy shall be ignored; a_wen/b_wen while busy shall be ignored (operands frozen).
REQ-028 a_wen/b_wen in IDLE write the addressed entry on the rising edge; out-of-range addresses are ignored.
REQ-029 start and a_wen/b_wen in the same IDLE cycle: the write completes and the run uses the new value.
REQ-030 M, N or P = 1 shall be supported (single-element dimensions).

Reset
REQ-031 On rst: state IDLE; c_out=0, c_row=0, c_col=0, c_valid=0, busy=0, done=0, overflow=0; internal C cleared to 0; A/B storage not cleared.
REQ-032 rst asserted mid-run shall abort immediately with no further c_valid or done; the run is not resumed.

Verification
REQ-033 Default params, A=[1 2 3;4 5 6], B=[1 0 -1 2;-2 3 0 1;2 1 1 -1], acc_mode=0, c_ready=1 -> c_out sequence 3,9,2,1,6,21,2,7 with matching (row,col); done after 8 transfers, 33 cycles; overflow=0.
REQ-034 Repeat the same run with acc_mode=1 -> 6,18,4,2,12,42,4,14.
REQ-035 Random c_ready (about 50% duty), including c_ready low for 5 cycles on element (0,1) -> c_out holds 9 stable; sequence unchanged; no element lost or duplicated.
REQ-036 DATA_WIDTH=8, all A and B = -128, SATURATE=1 -> every c_out = 32767, overflow=1; SATURATE=0 -> every c_out = -16384, overflow=1.
REQ-037 Assert rst during MAC of element (1,0) -> all outputs 0 next cycle, no done; a fresh start then reproduces the REQ-033 sequence.
REQ-038 start pulse and a_wen/b_wen writes while busy -> ignored; results identical to REQ-033.

Source files
------------

// File: rtl/matrix_mult_engine.sv
// matrix_mult_engine: sequential C = A*B (or C += A*B) engine.
// A (MxN) and B (NxP) are held in small register files loaded while idle.
// Each output element takes N multiply-accumulate cycles. The result is
// presented on a valid/ready port in row-major order. The accepted result is
// written back into an internal C store, which feeds accumulate mode.
module matrix_mult_engine #(
  parameter int M          = 2,
  parameter int N          = 3,
  parameter int P          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SATURATE   = 1,
  localparam int AW    = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int BW    = (N * P > 1) ? $clog2(N * P) : 1,
  localparam int RW    = (M > 1) ? $clog2(M) : 1,
  localparam int CW    = (P > 1) ? $clog2(P) : 1,
  localparam int OW    = 2 * DATA_WIDTH,
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(N) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  acc_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [AW-1:0]         a_addr,
  input  logic                  a_wen,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [BW-1:0]         b_addr,
  input  logic                  b_wen,
  output logic [OW-1:0]         c_out,
  output logic [RW-1:0]         c_row,
  output logic [CW-1:0]         c_col,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int CIW = (M * P > 1) ? $clog2(M * P) : 1;
  localparam int EXT = ACC_W - OW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] a_mem_r [M*N];
  logic [DATA_WIDTH-1:0] b_mem_r [N*P];
  logic [OW-1:0]         c_mem_r [M*P];
  logic [KW-1:0]         k_r;
  logic [RW-1:0]         row_r;
  logic [CW-1:0]         col_r;
  logic [ACC_W-1:0]      acc_r;
  logic                  prime_r;
  logic                  acc_mode_r;

  logic [AW-1:0]         a_idx_s;
  logic [BW-1:0]         b_idx_s;
  logic [CIW-1:0]        c_idx_s;
  logic [CIW-1:0]        c_nidx_s;
  logic [DATA_WIDTH-1:0] a_val_s;
  logic [DATA_WIDTH-1:0] b_val_s;
  logic [OW-1:0]         a_ext_s;
  logic [OW-1:0]         b_ext_s;
  logic [OW-1:0]         prod_s;
  logic [ACC_W-1:0]      acc_sum_s;
  logic [ACC_W-1:0]      c_init_s;
  logic [ACC_W-1:0]      c_ninit_s;
  logic                  k_last_s;
  logic                  e_last_s;
  logic                  fits_s;
  logic [OW-1:0]         result_s;

  // Sign-extend an OW-wide value to the accumulator width.
  function automatic logic [ACC_W-1:0] sext_fn(input logic [OW-1:0] v);
    return {{EXT{v[OW-1]}}, v};
  endfunction

  // True when the accumulator value is representable in signed OW bits.
  function automatic logic fits_fn(input logic [ACC_W-1:0] v);
    logic [EXT:0] top;
    top = v[ACC_W-1:OW-1];
    return (&top) | (~|top);
  endfunction

  // Reduce the accumulator to OW bits: pass, clamp, or wrap.
  function automatic logic [OW-1:0] result_fn(input logic [ACC_W-1:0] v);
    logic [OW-1:0] r;
    if (fits_fn(v) || (SATURATE == 0)) begin
      r = v[OW-1:0];
    end else if (v[ACC_W-1]) begin
      r = {1'b1, {(OW-1){1'b0}}};
    end else begin
      r = {1'b0, {(OW-1){1'b1}}};
    end
    return r;
  endfunction

  // Operand addressing, product, running sum and result shaping.
  always_comb begin
    a_idx_s   = AW'(32'(row_r) * 32'(N) + 32'(k_r));
    b_idx_s   = BW'(32'(k_r) * 32'(P) + 32'(col_r));
    c_idx_s   = CIW'(32'(row_r) * 32'(P) + 32'(col_r));
    c_nidx_s  = CIW'(32'(c_idx_s) + 32'd1);
    a_val_s   = a_mem_r[a_idx_s];
    b_val_s   = b_mem_r[b_idx_s];
    a_ext_s   = {{DATA_WIDTH{a_val_s[DATA_WIDTH-1]}}, a_val_s};
    b_ext_s   = {{DATA_WIDTH{b_val_s[DATA_WIDTH-1]}}, b_val_s};
    prod_s    = a_ext_s * b_ext_s;
    acc_sum_s = acc_r + sext_fn(prod_s);
    if (acc_mode_r) begin
      c_init_s  = sext_fn(c_mem_r[c_idx_s]);
      c_ninit_s = sext_fn(c_mem_r[c_nidx_s]);
    end else begin
      c_init_s  = '0;
      c_ninit_s = '0;
    end
    k_last_s  = (32'(k_r) == 32'(N - 1));
    e_last_s  = (32'(c_idx_s) == 32'(M * P - 1));
    fits_s    = fits_fn(acc_sum_s);
    result_s  = result_fn(acc_sum_s);
  end

  // Operand register files: writable only while idle, out-of-range dropped.
  always_ff @(posedge clk) begin
    if ((state_r == IDLE) && a_wen && (32'(a_addr) < 32'(M * N))) begin
      a_mem_r[a_addr] <= a_in;
    end
    if ((state_r == IDLE) && b_wen && (32'(b_addr) < 32'(N * P))) begin
      b_mem_r[b_addr] <= b_in;
    end
  end

  // Result store: cleared on reset, captures each accepted output element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M * P; i++) begin
        c_mem_r[i] <= '0;
      end
    end else if ((state_r == OUT) && c_valid && c_ready) begin
      c_mem_r[c_idx_s] <= c_out;
    end
  end

  // Control FSM with registered outputs.
  // After start, one priming cycle loads the accumulator. Each element then
  // takes N MAC cycles plus one hand-off cycle. The hand-off edge preloads the
  // accumulator for the next element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      k_r        <= '0;
      row_r      <= '0;
      col_r      <= '0;
      acc_r      <= '0;
      prime_r    <= 1'b0;
      acc_mode_r <= 1'b0;
      c_out      <= '0;
      c_row      <= '0;
      c_col      <= '0;
      c_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_mode_r <= acc_mode;
            overflow   <= 1'b0;
            row_r      <= '0;
            col_r      <= '0;
            k_r        <= '0;
            prime_r    <= 1'b1;
            busy       <= 1'b1;
            state_r    <= MAC;
          end else begin
            state_r <= IDLE;
          end
        end
        MAC: begin
          if (prime_r) begin
            acc_r   <= c_init_s;
            prime_r <= 1'b0;
          end else begin
            acc_r <= acc_sum_s;
            if (k_last_s) begin
              k_r      <= '0;
              c_out    <= result_s;
              c_row    <= row_r;
              c_col    <= col_r;
              c_valid  <= 1'b1;
              overflow <= overflow | ~fits_s;
              state_r  <= OUT;
            end else begin
              k_r <= k_r + KW'(1'b1);
            end
          end
        end
        OUT: begin
          if (c_valid && c_ready) begin
            c_valid <= 1'b0;
            if (e_last_s) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= FIN;
            end else begin
              if (32'(col_r) == 32'(P - 1)) begin
                col_r <= '0;
                row_r <= row_r + RW'(1'b1);
              end else begin
                col_r <= col_r + CW'(1'b1);
              end
              acc_r   <= c_ninit_s;
              state_r <= MAC;
            end
          end else begin
            state_r <= OUT;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Directed bench for matrix_mult_engine (default 2x3 * 3x4, 8-bit operands).
// Two instances share all inputs: dut1 saturates, dut2 wraps.
module tb_matrix_mult_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               acc_mode;
  logic [7:0]         a_in;
  logic [2:0]         a_addr;
  logic               a_wen;
  logic [7:0]         b_in;
  logic [3:0]         b_addr;
  logic               b_wen;
  logic               c_ready;
  logic signed [15:0] c_out1, c_out2;
  logic [0:0]         c_row1, c_row2;
  logic [1:0]         c_col1, c_col2;
  logic               c_valid1, c_valid2;
  logic               busy1, busy2;
  logic               done1, done2;
  logic               ovf1, ovf2;

  int total = 0;
  int bad   = 0;
  int seq    [8];
  int exp1   [8];
  int exp2   [8];
  int a_vals [6];
  int b_vals [12];

  matrix_mult_engine #(.SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
    .a_in(a_in), .a_addr(a_addr), .a_wen(a_wen),
    .b_in(b_in), .b_addr(b_addr), .b_wen(b_wen),
    .c_out(c_out1), .c_row(c_row1), .c_col(c_col1), .c_valid(c_valid1),
    .c_ready(c_ready), .busy(busy1), .done(done1), .overflow(ovf1)
  );

  matrix_mult_engine #(.SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
    .a_in(a_in), .a_addr(a_addr), .a_wen(a_wen),
    .b_in(b_in), .b_addr(b_addr), .b_wen(b_wen),
    .c_out(c_out2), .c_row(c_row2), .c_col(c_col2), .c_valid(c_valid2),
    .c_ready(c_ready), .busy(busy2), .done(done2), .overflow(ovf2)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
    end
  endtask

  // Load A and B; with sat set, every entry except A[0] becomes -128.
  task automatic load_ab(input logic sat);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_wen  = (i < 6);
      a_addr = 3'(i);
      a_in   = (sat && i != 0) ? 8'h80 : 8'(a_vals[i % 6]);
      b_wen  = 1'b1;
      b_addr = 4'(i);
      b_in   = sat ? 8'h80 : 8'(b_vals[i]);
    end
    @(negedge clk);
    a_wen  = 1'b1;
    a_addr = 3'd7;
    a_in   = 8'd77;
    b_wen  = 1'b1;
    b_addr = 4'd13;
    b_in   = 8'd77;
    @(negedge clk);
    a_wen = 1'b0;
    b_wen = 1'b0;
  endtask

  // One run: rmode 0 = ready high, 1 = random ready with a 5-cycle stall on (0,1).
  task automatic run(input string tag, input logic mode, input int rmode,
                     input int abort_cyc, input int exp_done, input logic exp_ovf,
                     input logic disturb, input logic start_wr);
    int  n = 0;
    int  hold = 0;
    int  done_cyc = -1;
    int  first_v = -1;
    int  viol = 0;
    logic ovf_d1 = 1'b0;
    logic ovf_d2 = 1'b0;
    logic busy_d = 1'b1;
    @(negedge clk);
    acc_mode = mode;
    start    = 1'b1;
    c_ready  = 1'b1;
    if (start_wr) begin
      a_wen  = 1'b1;
      a_addr = 3'd0;
      a_in   = 8'h80;
    end
    @(negedge clk);
    start = 1'b0;
    a_wen = 1'b0;
    chk(tag, "busy_after_start", int'(busy1), 1);
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a_wen = 1'b0;
      b_wen = 1'b0;
      if (cyc == abort_cyc) begin
        chk(tag, "xfers_before_abort", n, 4);
        rst = 1'b1;
        #1;
        chk(tag, "abort_outputs",
            int'({c_valid1, busy1, done1, ovf1, c_row1, c_col1}) + int'(c_out1), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int q = 0; q < 8; q++) begin
          @(negedge clk);
          if (c_valid1 || done1 || busy1) viol++;
        end
        chk(tag, "quiet_after_abort", viol, 0);
        return;
      end
      if (done1) begin
        done_cyc = cyc;
        ovf_d1   = ovf1;
        ovf_d2   = ovf2;
        busy_d   = busy1;
      end else begin
        if (c_valid1 && first_v < 0) first_v = cyc;
        if (rmode == 1) begin
          if (c_valid1 && c_row1 == 1'b0 && c_col1 == 2'd1 && hold < 5) begin
            c_ready = 1'b0;
            hold++;
            chk(tag, "held_value", int'(c_out1), exp1[1]);
          end else begin
            c_ready = 1'($urandom_range(0, 1));
          end
        end else begin
          c_ready = 1'b1;
        end
        if (c_valid1 && c_ready) begin
          if (n < 8) begin
            chk(tag, "c_out_sat", int'(c_out1), exp1[n]);
            chk(tag, "c_out_wrap", int'(c_out2), exp2[n]);
            chk(tag, "c_row", int'(c_row1), n / 4);
            chk(tag, "c_col", int'(c_col1), n % 4);
          end
          n++;
        end
        if (disturb && (cyc == 2 || cyc == 10)) begin
          start  = 1'b1;
          a_wen  = 1'b1;
          a_addr = 3'd0;
          a_in   = 8'd50;
          b_wen  = 1'b1;
          b_addr = 4'd0;
          b_in   = 8'd50;
        end
      end
    end
    c_ready = 1'b1;
    chk(tag, "transfers", n, 8);
    if (exp_done > 0) begin
      chk(tag, "done_cycle", done_cyc, exp_done);
      chk(tag, "first_valid_cycle", first_v, 4);
    end else begin
      chk(tag, "done_seen", int'(done_cyc > 0), 1);
    end
    chk(tag, "overflow_sat", int'(ovf_d1), int'(exp_ovf));
    chk(tag, "overflow_wrap", int'(ovf_d2), int'(exp_ovf));
    chk(tag, "busy_at_done", int'(busy_d), 0);
  endtask

  initial begin
    seq    = '{3, 9, 2, 1, 6, 21, 2, 7};
    a_vals = '{1, 2, 3, 4, 5, 6};
    b_vals = '{1, 0, -1, 2, -2, 3, 0, 1, 2, 1, 1, -1};
    rst = 1'b1; start = 1'b0; acc_mode = 1'b0; c_ready = 1'b1;
    a_in = 8'd0; a_addr = 3'd0; a_wen = 1'b0;
    b_in = 8'd0; b_addr = 4'd0; b_wen = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset", "c_valid", int'(c_valid1), 0);
    chk("reset", "busy", int'(busy1), 0);
    chk("reset", "done", int'(done1), 0);
    chk("reset", "overflow", int'(ovf1), 0);
    chk("reset", "c_out", int'(c_out1), 0);
    chk("reset", "row_col", int'({c_row1, c_col1}), 0);
    rst = 1'b0;

    load_ab(1'b0);
    for (int i = 0; i < 8; i++) begin exp1[i] = seq[i]; exp2[i] = seq[i]; end
    run("plain", 1'b0, 0, -1, 33, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin exp1[i] = 2 * seq[i]; exp2[i] = 2 * seq[i]; end
    run("accum", 1'b1, 0, -1, 33, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin exp1[i] = seq[i]; exp2[i] = seq[i]; end
    run("backpressure", 1'b0, 1, -1, -1, 1'b0, 1'b0, 1'b0);

    run("abort", 1'b0, 0, 18, 33, 1'b0, 1'b0, 1'b0);
    run("after_abort", 1'b1, 0, -1, 33, 1'b0, 1'b0, 1'b0);

    run("busy_ignore", 1'b0, 0, -1, 33, 1'b0, 1'b1, 1'b0);

    load_ab(1'b1);
    for (int i = 0; i < 8; i++) begin exp1[i] = 32767; exp2[i] = -16384; end
    run("saturate", 1'b0, 0, -1, 33, 1'b1, 1'b0, 1'b1);

    load_ab(1'b0);
    for (int i = 0; i < 8; i++) begin exp1[i] = seq[i]; exp2[i] = seq[i]; end
    run("ovf_cleared", 1'b0, 0, -1, 33, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
